// File: rtl/s208_run_ctrl.sv
// s208_run_ctrl: run controller for the combinational s208 fractional-multiplier core.
// Owns the core state register, steps the core for a bounded number of cycles
// per accepted command, collects the serial output history and hands the
// result back through a valid/ready interface.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high, core inhibited
// CLEAR | one cycle: core state register forced to zero before stepping
// RUN   | one core step per cycle until the counter expires or abort
// DONE  | result held on res_*; waits for res_ready
module s208_run_ctrl #(
  parameter int LEN_W = 8,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_sel,
  input  logic             cmd_clear,
  input  logic             cmd_abort,
  output logic             core_en,
  output logic             core_hold,
  output logic [7:0]       core_sel,
  output logic [7:0]       core_state,
  input  logic [7:0]       core_next,
  input  logic             core_tc,
  input  logic             core_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_tc,
  output logic [LEN_W-1:0] res_steps
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] STEPS_MAX = '1;
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       core_state_q, core_state_d;
  logic [7:0]       core_sel_q, core_sel_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic             res_tc_q, res_tc_d;
  logic [LEN_W-1:0] res_steps_q, res_steps_d;

  // Register bank: FSM, step counter, core state/select and result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_state_q <= '0;
      core_sel_q   <= '0;
      res_data_q   <= '0;
      res_tc_q     <= 1'b0;
      res_steps_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_state_q <= core_state_d;
      core_sel_q   <= core_sel_d;
      res_data_q   <= res_data_d;
      res_tc_q     <= res_tc_d;
      res_steps_q  <= res_steps_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_state_d = core_state_q;
    core_sel_d   = core_sel_q;
    res_data_d   = res_data_q;
    res_tc_d     = res_tc_q;
    res_steps_d  = res_steps_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is a decode of IDLE, so cmd_valid alone completes the handshake here.
        if (cmd_valid) begin
          cnt_d       = cmd_len;
          core_sel_d  = cmd_sel;
          res_data_d  = '0;
          res_tc_d    = 1'b0;
          res_steps_d = '0;
          if (cmd_clear) begin
            state_d = ST_CLEAR;
          end else if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_CLEAR: begin
        core_state_d = '0;
        state_d      = (cnt_q == '0) ? ST_DONE : ST_RUN;
      end

      ST_RUN: begin
        // Abort discards this cycle's step, including one that would have been the last.
        if (cmd_abort) begin
          state_d = ST_DONE;
        end else begin
          core_state_d = core_next;
          res_data_d   = {res_data_q[RES_W-2:0], core_y};
          res_tc_d     = res_tc_q | core_tc;
          if (res_steps_q != STEPS_MAX) begin
            res_steps_d = res_steps_q + CNT_ONE;
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and core control are pure decodes of the FSM register, so they
  // only ever change on a clock edge.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign res_valid  = (state_q == ST_DONE);
  assign core_en    = (state_q == ST_RUN);
  assign core_hold  = (state_q != ST_RUN);

  assign core_sel   = core_sel_q;
  assign core_state = core_state_q;
  assign res_data   = res_data_q;
  assign res_tc     = res_tc_q;
  assign res_steps  = res_steps_q;

endmodule

// File: tb/tb_s208_run_ctrl.sv
// Self-checking bench for s208_run_ctrl. The s208 core is stood in for by a
// simple arithmetic next-state function; a run-level reference model computes
// the expected final state, history, tc flag, step count and latency.
module tb_s208_run_ctrl;

  localparam int LEN_W = 8;
  localparam int RES_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       cmd_sel = '0;
  logic             cmd_clear = 1'b0;
  logic             cmd_abort = 1'b0;
  logic             core_en;
  logic             core_hold;
  logic [7:0]       core_sel;
  logic [7:0]       core_state;
  logic [7:0]       core_next;
  logic             core_tc;
  logic             core_y;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [RES_W-1:0] res_data;
  logic             res_tc;
  logic [LEN_W-1:0] res_steps;

  logic ovr = 1'b0;
  logic y_force = 1'b0;
  logic tc_force = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_state = 8'h00;
  logic [15:0] last_d = 16'h0000;

  typedef struct {
    int         len;
    bit         clr;
    logic [7:0] sel;
    int         ab;
    int         x_steps;
    int         x_lat;
    int         x_en;
  } vec_t;

  vec_t tbl[8];

  s208_run_ctrl #(.LEN_W(LEN_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_sel(cmd_sel), .cmd_clear(cmd_clear), .cmd_abort(cmd_abort),
    .core_en(core_en), .core_hold(core_hold), .core_sel(core_sel),
    .core_state(core_state), .core_next(core_next), .core_tc(core_tc),
    .core_y(core_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tc(res_tc), .res_steps(res_steps)
  );

  always #5 clk = ~clk;

  // Stand-in core: arithmetic next state, parity output, tc on low nibble all ones.
  function automatic logic [7:0] f_next(input logic [7:0] s, input logic [7:0] sel);
    int t;
    t = (int'(s) * 5 + int'(sel) + 1) % 256;
    return 8'(t);
  endfunction

  function automatic logic f_y(input logic [7:0] s, input logic [7:0] sel);
    return ^(s ^ sel);
  endfunction

  function automatic logic f_tc(input logic [7:0] s);
    return (s[3:0] == 4'hF);
  endfunction

  assign core_next = f_next(core_state, core_sel);
  assign core_y    = ovr ? y_force : f_y(core_state, core_sel);
  assign core_tc   = ovr ? tc_force : f_tc(core_state);

  // Run-level reference: how many steps happen, and what they accumulate.
  task automatic model(input logic [7:0] st0, input logic [7:0] sel, input int n,
                       input int ab, input bit clr,
                       output logic [7:0] st, output logic [15:0] d, output logic tc,
                       output int steps, output int lat, output int en);
    bit aborted;
    aborted = (ab >= 1) && (ab <= n);
    st = clr ? 8'h00 : st0;
    d = 16'h0000;
    tc = 1'b0;
    steps = aborted ? ab - 1 : n;
    for (int i = 0; i < steps; i++) begin
      d  = {d[14:0], f_y(st, sel)};
      tc = tc | f_tc(st);
      st = f_next(st, sel);
    end
    en  = aborted ? ab : n;
    lat = en + 1 + (clr ? 1 : 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    chk("res_valid_after_done", 32'(res_valid), 32'd0);
  endtask

  // Issue one command and follow it to DONE; x_* < 0 means take the model's value.
  task automatic run_cmd(input int len, input bit clr, input logic [7:0] sel, input int ab,
                         input int x_steps, input int x_lat, input int x_en, input bit hold);
    logic [7:0]  e_st;
    logic [15:0] e_d;
    logic        e_tc;
    int e_steps, e_lat, e_en, cnt, ri, enc;
    model(m_state, sel, len, ab, clr, e_st, e_d, e_tc, e_steps, e_lat, e_en);
    if (x_steps >= 0) e_steps = x_steps;
    if (x_lat >= 0) e_lat = x_lat;
    if (x_en >= 0) e_en = x_en;
    cmd_len   = LEN_W'(len);
    cmd_sel   = sel;
    cmd_clear = clr;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    chk("core_sel_latched", 32'(core_sel), 32'(sel));
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    cnt = 1;
    ri = 0;
    enc = 0;
    while (!res_valid && cnt < 600) begin
      if (core_en) begin
        ri++;
        enc++;
      end
      cmd_abort = core_en && (ri == ab);
      @(posedge clk); #1;
      cmd_abort = 1'b0;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(e_lat));
    chk("en_cycles", 32'(enc), 32'(e_en));
    chk("res_steps", 32'(res_steps), 32'(e_steps));
    chk("core_state", 32'(core_state), 32'(e_st));
    chk("res_data", 32'(res_data), 32'(e_d));
    chk("res_tc", 32'(res_tc), 32'(e_tc));
    chk("done_hold", 32'({core_en, core_hold}), 32'b01);
    m_state = e_st;
    last_d  = e_d;
    if (!hold) handshake();
  endtask

  initial begin
    tbl[0] = '{len: 5,   clr: 1'b1, sel: 8'hA5, ab: 0, x_steps: 5,   x_lat: 7,   x_en: 5};
    tbl[1] = '{len: 0,   clr: 1'b0, sel: 8'h3C, ab: 0, x_steps: 0,   x_lat: 1,   x_en: 0};
    tbl[2] = '{len: 20,  clr: 1'b0, sel: 8'h11, ab: 4, x_steps: 3,   x_lat: 5,   x_en: 4};
    tbl[3] = '{len: 0,   clr: 1'b1, sel: 8'h00, ab: 0, x_steps: 0,   x_lat: 2,   x_en: 0};
    tbl[4] = '{len: 1,   clr: 1'b0, sel: 8'h7E, ab: 0, x_steps: 1,   x_lat: 2,   x_en: 1};
    tbl[5] = '{len: 3,   clr: 1'b1, sel: 8'h42, ab: 1, x_steps: 0,   x_lat: 3,   x_en: 1};
    tbl[6] = '{len: 2,   clr: 1'b0, sel: 8'h99, ab: 2, x_steps: 1,   x_lat: 3,   x_en: 2};
    tbl[7] = '{len: 255, clr: 1'b0, sel: 8'h01, ab: 0, x_steps: 255, x_lat: 256, x_en: 255};

    // Reset values.
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_core_state", 32'(core_state), 32'd0);
    chk("rst_res_steps", 32'(res_steps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven runs, state carried between rows.
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].len, tbl[i].clr, tbl[i].sel, tbl[i].ab,
              tbl[i].x_steps, tbl[i].x_lat, tbl[i].x_en, 1'b0);
    end

    // History and tc: 18 steps of alternating y, one tc pulse on step 7.
    ovr = 1'b1;
    cmd_len = 8'd18; cmd_sel = 8'h33; cmd_clear = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      y_force  = k[0];
      tc_force = (k == 7);
      @(posedge clk); #1;
    end
    tc_force = 1'b0;
    chk("hist_valid", 32'(res_valid), 32'd1);
    chk("hist_data", 32'(res_data), 32'h5555);
    chk("hist_tc", 32'(res_tc), 32'd1);
    chk("hist_steps", 32'(res_steps), 32'd18);
    for (int k = 0; k < 18; k++) m_state = f_next(m_state, 8'h33);
    chk("hist_state", 32'(core_state), 32'(m_state));
    ovr = 1'b0;
    handshake();

    // Backpressure in DONE with an ignored command, then a continuation run.
    run_cmd(9, 1'b0, 8'h6B, 0, -1, -1, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 4);
      cmd_len   = 8'd3;
      cmd_clear = (i == 4);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'(last_d));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    chk("bp_state_kept", 32'(core_state), 32'(m_state));
    chk("bp_en_low", 32'(core_en), 32'd0);
    handshake();
    run_cmd(6, 1'b0, 8'h21, 0, -1, -1, -1, 1'b0);

    // Randomised runs against the reference model.
    for (int r = 0; r < 20; r++) begin
      int len, ab;
      bit clr;
      logic [7:0] sel;
      len = int'($urandom_range(40, 0));
      clr = ($urandom_range(3, 0) == 0);
      sel = 8'($urandom);
      ab  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len + 2, 1)) : 0;
      run_cmd(len, clr, sel, ab, -1, -1, -1, 1'b0);
    end

    // Asynchronous reset during the second RUN cycle.
    cmd_len = 8'd10; cmd_sel = 8'h5A; cmd_clear = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_core_en", 32'(core_en), 32'd0);
    chk("mr_core_hold", 32'(core_hold), 32'd1);
    chk("mr_core_sel", 32'(core_sel), 32'd0);
    chk("mr_core_state", 32'(core_state), 32'd0);
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    chk("mr_res_data", 32'(res_data), 32'd0);
    chk("mr_res_tc", 32'(res_tc), 32'd0);
    chk("mr_res_steps", 32'(res_steps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 8'h00;
    @(posedge clk); #1;
    run_cmd(4, 1'b0, 8'hC3, 0, 4, 5, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s208_run_ctrl.md
# s208_run_ctrl

Run controller for the s208 fractional-multiplier core, whose next-state logic is purely combinational. The block owns the core's 8-bit state register, feeds it back each step, and sequences bounded runs of N steps under a valid/ready command interface. During a run it collects the core's serial output bit and reports completion through a valid/ready result interface. It sits between the benchmark-level control logic and the combinational core, and is the only driver of the core's state and enable inputs.

## Interface
- LEN_W, 8, width of the step-count field; a run is 1..2^LEN_W-1 steps.
- RES_W, 16, depth of the collected serial-output history.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command. High only in IDLE.
- cmd_len  in  LEN_W  number of core steps to execute.
- cmd_sel  in  8  operand/select word for the core, held for the whole run.
- cmd_clear  in  1  zero the core state before stepping.
- cmd_abort  in  1  stop the current run early. Sampled only in RUN.
- core_en  out  1  core enable (core input pi00).
- core_hold  out  1  core inhibit (core input pi01).
- core_sel  out  8  registered copy of cmd_sel.
- core_state  out  8  current state register, fed to the core state inputs.
- core_next  in  8  next state computed by the core.
- core_tc  in  1  core terminal-count flag.
- core_y  in  1  core serial data output.
- res_valid  out  1  result available. High only in DONE.
- res_ready  in  1  result consumed.
- res_data  out  RES_W  last RES_W samples of core_y. Bit 0 holds the newest sample.
- res_tc  out  1  core_tc was seen high on at least one step of the run.
- res_steps  out  LEN_W  number of steps actually executed.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- Reset values:
  - FSM: IDLE.
  - core_state, core_sel, res_data, res_steps: 0.
  - res_tc, res_valid, core_en: 0.
  - core_hold: 1.
  - cmd_ready: 1.
- IDLE:
  - Drives core_en=0, core_hold=1.
  - On cmd_valid&&cmd_ready:
    - Latch cmd_len into the down-counter and cmd_sel into core_sel.
    - Clear res_data, res_tc and res_steps.
  - Next state:
    - CLEAR if cmd_clear=1.
    - DONE if cmd_len==0 (no step is executed).
    - Otherwise RUN.
- CLEAR: one cycle only.
  - core_state<=0, core_en=0.
  - Next state is DONE if the latched length is 0, otherwise RUN.
- RUN: one step per cycle.
  - Drives core_en=1, core_hold=0.
  - On each edge:
    - core_state<=core_next.
    - res_data<={res_data[RES_W-2:0],core_y}.
    - res_tc<=res_tc|core_tc.
    - res_steps<=res_steps+1 (saturates at 2^LEN_W-1).
    - counter decrements.
  - When the counter equals 1, that step is the last one; the next state is DONE.
- Abort in RUN:
  - If cmd_abort=1, the current cycle's step is not taken: core_state, res_* and the counter hold.
  - The FSM goes to DONE.
  - Abort takes priority over a last step in the same cycle.
- DONE:
  - res_valid=1. All outputs hold.
  - On res_ready goes to IDLE. core_state is retained across runs, so a later run without cmd_clear continues from it.
- cmd_valid while not in IDLE is ignored. It is not queued.
- Asynchronous reset mid-run returns all registers to their reset values immediately. The partial result is discarded.

## Timing
- Command accept edge T0.
- Without clear:
  - RUN occupies cycles T0+1 .. T0+N; core_state updates at the end of each of those cycles.
  - res_valid rises at T0+N+1.
- With clear:
  - CLEAR occupies cycle T0+1.
  - RUN occupies T0+2 .. T0+N+1.
  - res_valid rises at T0+N+2.
- Zero-length command: res_valid is high 1 cycle after accept, or 2 cycles after accept with clear.
- res_valid&&res_ready on edge Tr: cmd_ready is high in cycle Tr+1, and a new command can be accepted at the Tr+1 edge. Minimum issue interval is N+2 cycles.
- Timing of core_en and core_hold:
  - Both are pure decodes of the FSM register.
  - Both change only on clock edges.
- Samples feeding core_tc and core_y are taken combinationally off the core in the same cycle as core_state.

## Test plan
- Basic run: reset; cmd_len=5, cmd_clear=1, cmd_sel=8'hA5 -> core_sel=8'hA5 from T0+1; core_en high exactly 5 cycles; res_valid at T0+7; res_steps=5; core_state equals the 5th iterate of core_next from 0.
- Zero length: cmd_len=0, cmd_clear=0 -> core_en never rises; res_valid 1 cycle after accept; res_steps=0; core_state unchanged.
- Abort: cmd_len=20; cmd_abort at the 4th RUN cycle -> res_steps=3; DONE next cycle; core_state equals the 3rd iterate.
- History and tc: model the core with core_y toggling and core_tc pulsed once; run of 18 steps -> res_data holds the last 16 y samples (newest in bit 0); res_tc=1.
- Backpressure and continuation: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0, and a cmd_valid pulse in DONE is ignored. Then release res_ready and issue a second run without clear -> it starts from the retained core_state.
- Reset mid-run: assert rst_n low during RUN cycle 2, asynchronously -> all outputs at reset values before the next edge; FSM in IDLE.
